// File: rtl/pp_loop_monitor.sv
// Pipelined-loop monitor: tracks iterations in flight, loop completion and protocol errors.
// Optional stall counter is built when PP_LOOP_MON_STALL_EN is defined.
module pp_loop_monitor #(
  parameter int FSM_WIDTH    = 2,
  parameter int CNT_WIDTH    = 16,
  parameter int MAX_INFLIGHT = 8,
  localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [FSM_WIDTH-1:0] cur_state,
  input  logic [FSM_WIDTH-1:0] iter_start_state,
  input  logic [FSM_WIDTH-1:0] iter_end_state,
  input  logic [FSM_WIDTH-1:0] loop_quit_state,
  input  logic                 iter_start_enable,
  input  logic                 iter_start_block,
  input  logic                 iter_end_enable,
  input  logic                 iter_end_block,
  input  logic                 quit_at_end,
  input  logic                 finish,
  input  logic                 clr_err,
  output logic                 loop_active,
  output logic [1:0]           mon_state,
  output logic [IW-1:0]        inflight,
  output logic [CNT_WIDTH-1:0] iter_started,
  output logic [CNT_WIDTH-1:0] iter_ended,
  output logic                 loop_done,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic                 err_quit,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 frozen;
  logic                 s_ev, e_ev, q_ev, s_cnt;
  logic [IW-1:0]        infl_d;
  logic [CNT_WIDTH-1:0] st_d, en_d;
  logic                 set_ov, set_un, set_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  assign s_ev = (cur_state == iter_start_state)
              & iter_start_enable & ~iter_start_block;
  assign e_ev = (cur_state == iter_end_state)
              & iter_end_enable & ~iter_end_block;
  assign q_ev = (cur_state == loop_quit_state);

  assign mon_state   = state_q;
  assign loop_active = (state_q == RUN) || (state_q == DRAIN);

  always_comb begin
    state_d = state_q;
    infl_d  = inflight;
    st_d    = iter_started;
    en_d    = iter_ended;
    set_ov  = 1'b0;
    set_un  = 1'b0;
    set_q   = 1'b0;
    s_cnt   = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (s_ev) begin
          state_d = RUN;
          st_d    = CNT_WIDTH'(1);
          en_d    = '0;
          infl_d  = IW'(1);
        end
        if (e_ev) set_un = 1'b1;
      end
      (state_q == RUN), (state_q == DRAIN): begin
        // Starts are only legal while running; in drain they flag a quit error.
        s_cnt = s_ev && (state_q == RUN);
        if (s_ev && state_q == DRAIN) set_q = 1'b1;
        if (s_cnt && e_ev) begin
          st_d = sat_inc(iter_started);
          en_d = sat_inc(iter_ended);
        end else if (s_cnt) begin
          if (inflight == IW'(MAX_INFLIGHT)) set_ov = 1'b1;
          else begin
            st_d   = sat_inc(iter_started);
            infl_d = inflight + 1'b1;
          end
        end else if (e_ev) begin
          if (inflight == '0) set_un = 1'b1;
          else begin
            en_d   = sat_inc(iter_ended);
            infl_d = inflight - 1'b1;
          end
        end
        if (state_q == RUN) begin
          if (q_ev) begin
            state_d = (infl_d == '0) ? DONE : DRAIN;
            if (quit_at_end && (!e_ev || infl_d != '0)) set_q = 1'b1;
          end
        end else if (infl_d == '0) begin
          state_d = DONE;
        end
      end
      (state_q == DONE): state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      frozen        <= 1'b0;
      inflight      <= '0;
      iter_started  <= '0;
      iter_ended    <= '0;
      loop_done     <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_quit      <= 1'b0;
    end else begin
      if (finish) frozen <= 1'b1;
      if (finish || frozen) begin
        loop_done <= 1'b0;
      end else begin
        state_q       <= state_d;
        inflight      <= infl_d;
        iter_started  <= st_d;
        iter_ended    <= en_d;
        loop_done     <= (state_d == DONE);
        err_overflow  <= (err_overflow & ~clr_err) | set_ov;
        err_underflow <= (err_underflow & ~clr_err) | set_un;
        err_quit      <= (err_quit & ~clr_err) | set_q;
      end
    end
  end

`ifdef PP_LOOP_MON_STALL_EN
  logic [CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!(finish || frozen)) begin
      if (state_q == IDLE && state_d == RUN)
        stall_q <= '0;
      else if (loop_active && (iter_start_block | iter_end_block))
        stall_q <= sat_inc(stall_q);
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pp_loop_monitor.sv
// Scoreboard bench for pp_loop_monitor: directed steps push expected
// snapshots, a negedge monitor pops and compares.
module tb_pp_loop_monitor;

  localparam int CW = 3;
  localparam int MI = 3;
  localparam int IW = 2;
`ifdef PP_LOOP_MON_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]    st;
    logic [IW-1:0] inf;
    logic [CW-1:0] s;
    logic [CW-1:0] e;
    logic          d;
    logic          eo;
    logic          eu;
    logic          eq;
    logic [CW-1:0] stl;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    cur_state, iter_start_state, iter_end_state, loop_quit_state;
  logic          iter_start_enable, iter_start_block;
  logic          iter_end_enable, iter_end_block;
  logic          quit_at_end, finish, clr_err;
  logic          loop_active, loop_done;
  logic [1:0]    mon_state;
  logic [IW-1:0] inflight;
  logic [CW-1:0] iter_started, iter_ended, stall_cycles;
  logic          err_overflow, err_underflow, err_quit;

  exp_t sbq[$];
  int   tagq[$];
  int   checks = 0;
  int   errors = 0;
  int   n = 0;

  always #5 clock = ~clock;

  pp_loop_monitor #(
    .FSM_WIDTH(2),
    .CNT_WIDTH(CW),
    .MAX_INFLIGHT(MI)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cur_state(cur_state),
    .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state),
    .loop_quit_state(loop_quit_state),
    .iter_start_enable(iter_start_enable),
    .iter_start_block(iter_start_block),
    .iter_end_enable(iter_end_enable),
    .iter_end_block(iter_end_block),
    .quit_at_end(quit_at_end),
    .finish(finish),
    .clr_err(clr_err),
    .loop_active(loop_active),
    .mon_state(mon_state),
    .inflight(inflight),
    .iter_started(iter_started),
    .iter_ended(iter_ended),
    .loop_done(loop_done),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow),
    .err_quit(err_quit),
    .stall_cycles(stall_cycles)
  );

  function automatic exp_t ex(int st, int inf, int s, int e, int d,
                              int eo, int eu, int eq, int stl);
    exp_t x;
    x.st  = 2'(st);
    x.inf = IW'(inf);
    x.s   = CW'(s);
    x.e   = CW'(e);
    x.d   = 1'(d);
    x.eo  = 1'(eo);
    x.eu  = 1'(eu);
    x.eq  = 1'(eq);
    x.stl = STALL ? CW'(stl) : '0;
    return x;
  endfunction

  always @(negedge clock) begin
    exp_t x;
    exp_t g;
    int   t;
    logic la_exp;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      t = tagq.pop_front();
      g = {mon_state, inflight, iter_started, iter_ended, loop_done,
           err_overflow, err_underflow, err_quit, stall_cycles};
      la_exp = (x.st == 2'd1) || (x.st == 2'd2);
      checks++;
      if (g !== x || loop_active !== la_exp) begin
        errors++;
        $display("FAIL step%0d got st=%0d inf=%0d s=%0d e=%0d d=%0d la=%0d err=%b%b%b stall=%0d exp st=%0d inf=%0d s=%0d e=%0d d=%0d la=%0d err=%b%b%b stall=%0d",
          t, g.st, g.inf, g.s, g.e, g.d, loop_active, g.eo, g.eu, g.eq, g.stl,
          x.st, x.inf, x.s, x.e, x.d, la_exp, x.eo, x.eu, x.eq, x.stl);
      end
    end
  end

  task automatic step(input logic [1:0] cs, input bit s, input bit e,
                      input bit q, input bit sb, input bit eb,
                      input bit qae, input bit fin, input bit clr,
                      input bit rst, input exp_t x);
    cur_state         = cs;
    loop_quit_state   = q ? cs : cs + 2'd1;
    iter_start_enable = s;
    iter_end_enable   = e;
    iter_start_block  = sb;
    iter_end_block    = eb;
    quit_at_end       = qae;
    finish            = fin;
    clr_err           = clr;
    reset             = rst;
    @(posedge clock);
    sbq.push_back(x);
    tagq.push_back(n);
    n++;
    @(negedge clock);
  endtask

  initial begin
    iter_start_state = 2'd1;
    iter_end_state   = 2'd1;
    cur_state        = 2'd0;
    loop_quit_state  = 2'd2;
    {iter_start_enable, iter_end_enable, iter_start_block, iter_end_block} = '0;
    {quit_at_end, finish, clr_err} = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);

    step(1,0,0,0,0,0,0,0,0,1, ex(0,0,0,0,0,0,0,0,0));
    // basic loop, quit with last end
    step(1,1,0,0,0,0,1,0,0,0, ex(1,1,1,0,0,0,0,0,0));
    step(1,1,0,0,0,0,1,0,0,0, ex(1,2,2,0,0,0,0,0,0));
    step(1,1,0,0,0,0,1,0,0,0, ex(1,3,3,0,0,0,0,0,0));
    step(1,0,1,0,0,0,1,0,0,0, ex(1,2,3,1,0,0,0,0,0));
    step(1,0,1,0,0,0,1,0,0,0, ex(1,1,3,2,0,0,0,0,0));
    step(1,0,1,1,0,0,1,0,0,0, ex(3,0,3,3,1,0,0,0,0));
    step(1,0,0,0,0,0,0,0,0,0, ex(0,0,3,3,0,0,0,0,0));
    // overflow and clear
    step(1,1,0,0,0,0,0,0,0,0, ex(1,1,1,0,0,0,0,0,0));
    step(1,1,0,0,0,0,0,0,0,0, ex(1,2,2,0,0,0,0,0,0));
    step(1,1,0,0,0,0,0,0,0,0, ex(1,3,3,0,0,0,0,0,0));
    step(1,1,0,0,0,0,0,0,0,0, ex(1,3,3,0,0,1,0,0,0));
    step(1,0,0,0,0,0,0,0,1,0, ex(1,3,3,0,0,0,0,0,0));
    // drain path with a start during drain
    step(1,0,1,0,0,0,0,0,0,0, ex(1,2,3,1,0,0,0,0,0));
    step(1,0,0,1,0,0,0,0,0,0, ex(2,2,3,1,0,0,0,0,0));
    step(1,1,0,0,0,0,0,0,0,0, ex(2,2,3,1,0,0,0,1,0));
    step(1,0,1,0,0,0,0,0,0,0, ex(2,1,3,2,0,0,0,1,0));
    step(1,0,1,0,0,0,0,0,0,0, ex(3,0,3,3,1,0,0,1,0));
    step(1,0,0,0,0,0,0,0,0,0, ex(0,0,3,3,0,0,0,1,0));
    step(1,0,0,0,0,0,0,0,1,0, ex(0,0,3,3,0,0,0,0,0));
    // simultaneous start/end, underflow, no-match, blocking
    step(1,1,0,0,0,0,0,0,0,0, ex(1,1,1,0,0,0,0,0,0));
    step(1,1,1,0,0,0,0,0,0,0, ex(1,1,2,1,0,0,0,0,0));
    step(1,0,1,0,0,0,0,0,0,0, ex(1,0,2,2,0,0,0,0,0));
    step(1,0,1,0,0,0,0,0,0,0, ex(1,0,2,2,0,0,1,0,0));
    step(0,1,1,0,0,0,0,0,0,0, ex(1,0,2,2,0,0,1,0,0));
    step(1,1,0,0,1,0,0,0,0,0, ex(1,0,2,2,0,0,1,0,1));
    for (int k = 2; k <= 5; k++)
      step(1,1,0,0,1,0,0,0,0,0, ex(1,0,2,2,0,0,1,0,k));
    step(1,0,1,0,0,1,0,0,1,0, ex(1,0,2,2,0,0,0,0,6));
    step(1,0,1,0,0,0,0,0,1,0, ex(1,0,2,2,0,0,1,0,6));
    // counter saturation
    for (int i = 1; i <= 6; i++)
      step(1,1,1,0,0,0,0,0,0,0,
           ex(1,0,(2+i > 7) ? 7 : 2+i,(2+i > 7) ? 7 : 2+i,0,0,1,0,6));
    step(1,0,0,1,0,0,0,0,0,0, ex(3,0,7,7,1,0,1,0,6));
    step(1,0,0,0,0,0,0,0,1,0, ex(0,0,7,7,0,0,0,0,6));
    step(1,0,1,0,0,0,0,0,0,0, ex(0,0,7,7,0,0,1,0,6));
    // freeze, then reset out of it
    step(1,1,0,0,0,0,0,0,0,0, ex(1,1,1,0,0,0,1,0,0));
    step(1,0,0,0,1,0,0,0,0,0, ex(1,1,1,0,0,0,1,0,1));
    step(1,0,0,0,0,0,0,1,0,0, ex(1,1,1,0,0,0,1,0,1));
    step(1,1,0,0,1,0,0,0,0,0, ex(1,1,1,0,0,0,1,0,1));
    step(1,0,1,0,0,0,0,0,1,0, ex(1,1,1,0,0,0,1,0,1));
    step(1,0,1,1,0,0,1,0,0,0, ex(1,1,1,0,0,0,1,0,1));
    step(1,1,0,0,0,0,0,0,0,1, ex(0,0,0,0,0,0,0,0,0));
    step(1,1,0,0,0,0,0,0,0,0, ex(1,1,1,0,0,0,0,0,0));

    @(posedge clock);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
